// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder with auto-scan.
package decoder_pkg;

    localparam int unsigned ONEHOT_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    // Wide one-hot vector; callers truncate to their own output width.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Cycles-per-slot counter; tc marks the last cycle of the current slot.
module dwell_counter #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clr,
    input  logic [DWELL_W-1:0] Dwell,
    output logic               tc
);

    logic [DWELL_W-1:0] count;

    // >= lets a lowered Dwell end the slot immediately instead of overrunning.
    assign tc = (count >= Dwell);

    always_ff @(posedge Clock) begin
        if (Reset || clr || tc) begin
            count <= '0;
        end else begin
            count <= count + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/decoder_seq_n.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode
// that walks the asserted bit across all outputs with a programmable dwell.
module decoder_seq_n
    import decoder_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               En,
    input  logic               Mode,
    input  logic [N-1:0]       W,
    input  logic [DWELL_W-1:0] Dwell,
    output logic [2**N-1:0]    Y,
    output logic [N-1:0]       Idx,
    output logic               Busy,
    output logic               Wrap
);

    localparam int unsigned OUT_W = 2**N;

    state_t state;
    logic   steady;
    logic   clr;
    logic   tc;

    // The dwell count only runs while staying in SCAN; every other path restarts it.
    assign steady = (state == SCAN) && En && Mode;
    assign clr    = !steady;

    dwell_counter #(
        .DWELL_W(DWELL_W)
    ) u_dwell (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (clr),
        .Dwell (Dwell),
        .tc    (tc)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            Y     <= '0;
            Idx   <= '0;
            Busy  <= 1'b0;
            Wrap  <= 1'b0;
        end else if (!En) begin
            state <= IDLE;
            Y     <= '0;
            Idx   <= '0;
            Busy  <= 1'b0;
            Wrap  <= 1'b0;
        end else if (!Mode) begin
            state <= DIRECT;
            Y     <= OUT_W'(onehot(32'(W)));
            Idx   <= W;
            Busy  <= 1'b0;
            Wrap  <= 1'b0;
        end else if (state != SCAN) begin
            // Any entry into scan restarts at slot 0.
            state <= SCAN;
            Y     <= OUT_W'(1);
            Idx   <= '0;
            Busy  <= 1'b1;
            Wrap  <= 1'b0;
        end else if (tc) begin
            state <= SCAN;
            Y     <= {Y[OUT_W-2:0], Y[OUT_W-1]};
            Idx   <= Idx + N'(1);
            Busy  <= 1'b1;
            Wrap  <= (Idx == N'(OUT_W - 1));
        end else begin
            state <= SCAN;
            Busy  <= 1'b1;
            Wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_seq_n.sv
// Self-checking bench for decoder_seq_n: directed scenarios plus randomized traffic
// compared every cycle against a slot/phase model of the decoder.
module tb_decoder_seq_n;

    localparam int unsigned N     = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned OUT_W = 4;

    logic             Clock;
    logic             Reset;
    logic             En;
    logic             Mode;
    logic [N-1:0]     W;
    logic [DW-1:0]    Dwell;
    logic [OUT_W-1:0] Y;
    logic [N-1:0]     Idx;
    logic             Busy;
    logic             Wrap;

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 0;

    decoder_seq_n #(.N(N), .DWELL_W(DW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .En    (En),
        .Mode  (Mode),
        .W     (W),
        .Dwell (Dwell),
        .Y     (Y),
        .Idx   (Idx),
        .Busy  (Busy),
        .Wrap  (Wrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // phase: 0 idle, 1 direct, 2 scan; slot is the scan position, cnt cycles spent in it.
    typedef struct {
        int               phase;
        int               slot;
        int               cnt;
        logic [OUT_W-1:0] y;
        logic [N-1:0]     idx;
        logic             busy;
        logic             wrap;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t s, input logic rst, input logic en,
                                    input logic md, input logic [N-1:0] w,
                                    input logic [DW-1:0] dw);
        model_t r;
        r = s;
        r.wrap = 1'b0;
        if (rst || !en) begin
            r.phase = 0; r.slot = 0; r.cnt = 0;
            r.y = '0; r.idx = '0; r.busy = 1'b0;
        end else if (!md) begin
            r.phase = 1;
            r.y = OUT_W'(1) << w; r.idx = w; r.busy = 1'b0;
        end else begin
            if (s.phase != 2) begin
                r.phase = 2; r.slot = 0; r.cnt = 0;
            end else if (s.cnt >= int'(dw)) begin
                r.slot = (s.slot + 1) % OUT_W;
                r.cnt  = 0;
                r.wrap = (r.slot == 0);
            end else begin
                r.cnt = s.cnt + 1;
            end
            r.y = OUT_W'(1) << r.slot; r.idx = N'(r.slot); r.busy = 1'b1;
        end
        return r;
    endfunction

    always @(posedge Clock) m <= step(m, Reset, En, Mode, W, Dwell);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge Clock) begin
        if (check_en) begin
            check("model_y",    64'(Y),    64'(m.y));
            check("model_idx",  64'(Idx),  64'(m.idx));
            check("model_busy", 64'(Busy), 64'(m.busy));
            check("model_wrap", 64'(Wrap), 64'(m.wrap));
            check("inv_onehot0", 64'($onehot0(Y)), 64'(1));
            check("inv_idx", 64'((Y == '0) ? (Idx == '0) : (Y == (OUT_W'(1) << Idx))), 64'(1));
            check("inv_wrap_busy", 64'(!Wrap || Busy), 64'(1));
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int wraps;
        m = '{phase: 0, slot: 0, cnt: 0, y: '0, idx: '0, busy: 1'b0, wrap: 1'b0};
        Reset = 1'b1; En = 1'b1; Mode = 1'b1; W = '0; Dwell = 8'd2;

        // Reset wins over En/Mode.
        cyc();
        check_en = 1;
        cyc();
        check("rst_y", 64'(Y), 64'h0);
        check("rst_idx", 64'(Idx), 64'h0);
        check("rst_busy", 64'(Busy), 64'h0);
        check("rst_wrap", 64'(Wrap), 64'h0);

        // Direct decode with one-cycle latency.
        Reset = 1'b0; Mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            W = N'(i);
            cyc();
            check("direct_y", 64'(Y), 64'(4'b0001 << i));
            check("direct_idx", 64'(Idx), 64'(i));
        end
        En = 1'b0;
        cyc();
        check("direct_off_y", 64'(Y), 64'h0);

        // Scan with Dwell=2: three cycles per slot, one wrap on the 12th cycle.
        En = 1'b1; Mode = 1'b1; Dwell = 8'd2;
        cyc();
        check("scan_entry_y", 64'(Y), 64'b0001);
        check("scan_entry_busy", 64'(Busy), 64'h1);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("scan_d2_y", 64'(Y), 64'(4'b0001 << ((k / 3) % 4)));
            check("scan_d2_wrap", 64'(Wrap), 64'(k == 12));
        end

        // Dwell=0: advance every cycle, two wraps in eight cycles.
        Dwell = 8'd0;
        wraps = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            wraps += int'(Wrap);
        end
        check("scan_d0_wraps", 64'(wraps), 64'd2);
        check("scan_d0_y", 64'(Y), 64'b0001);

        // Lower Dwell from 5 to 1 with count already at 3.
        Dwell = 8'd5;
        cyc(); cyc(); cyc();
        check("drop_hold_y", 64'(Y), 64'b0001);
        Dwell = 8'd1;
        cyc();
        check("drop_adv_y", 64'(Y), 64'b0010);

        // Leave scan at slot 3 into direct, then re-enter scan.
        Dwell = 8'd0;
        cyc(); cyc();
        check("slot3_y", 64'(Y), 64'b1000);
        Mode = 1'b0; W = 2'd2;
        cyc();
        check("exit_direct_y", 64'(Y), 64'b0100);
        check("exit_direct_busy", 64'(Busy), 64'h0);
        check("exit_direct_idx", 64'(Idx), 64'd2);
        Mode = 1'b1;
        cyc();
        check("reenter_y", 64'(Y), 64'b0001);
        check("reenter_busy", 64'(Busy), 64'h1);

        // Mid-scan reset, then mid-scan !En together with Mode=0.
        cyc();
        Reset = 1'b1;
        cyc();
        check("midrst_y", 64'(Y), 64'h0);
        check("midrst_busy", 64'(Busy), 64'h0);
        Reset = 1'b0;
        cyc(); cyc();
        check("resume_y", 64'(Y), 64'b0010);
        En = 1'b0; Mode = 1'b0;
        cyc();
        check("off_y", 64'(Y), 64'h0);
        check("off_busy", 64'(Busy), 64'h0);
        check("off_idx", 64'(Idx), 64'h0);

        // Randomized traffic against the model.
        En = 1'b1; Mode = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            Reset = ($urandom_range(0, 99) == 0);
            En    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) Mode = ~Mode;
            W = N'($urandom_range(0, OUT_W - 1));
            if ($urandom_range(0, 31) == 0) Dwell = DW'($urandom_range(0, 3));
            cyc();
        end

        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
